// File: rtl/led_pkg.sv
// Shared types and sizing helpers for the WS2812-style LED frame sequencer.
package led_pkg;

    localparam int PIXEL_BITS = 24;

    typedef logic [PIXEL_BITS-1:0] pixel_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2,
        ST_LATCH = 2'd3
    } led_state_t;

    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

    function automatic int cnt_width(input int bit_cycles, input int reset_cycles);
        return clog2_min1((bit_cycles > reset_cycles) ? bit_cycles : reset_cycles);
    endfunction

endpackage

// File: rtl/led_bit_timer.sv
// Shared bit-period / latch-gap cycle counter and the registered NRZ high-time compare.
module led_bit_timer
    import led_pkg::*;
#(
    parameter int T0H_CYCLES   = 20,
    parameter int T1H_CYCLES   = 40,
    parameter int BIT_CYCLES   = 62,
    parameter int RESET_CYCLES = 15000
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic clr,
    input  logic send_next,
    input  logic bit_next,
    output logic bit_end,
    output logic latch_end,
    output logic strip_out
);

    localparam int CNT_W = cnt_width(BIT_CYCLES, RESET_CYCLES);
    localparam logic [CNT_W-1:0] T0H_C      = CNT_W'(T0H_CYCLES);
    localparam logic [CNT_W-1:0] T1H_C      = CNT_W'(T1H_CYCLES);
    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(RESET_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = clr ? '0 : count_q + CNT_W'(1);
    end

    // The line level is computed from the count the next cycle will hold,
    // so the registered output lines up with that cycle's count.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            count_q   <= '0;
            strip_out <= 1'b0;
        end else begin
            count_q   <= count_d;
            strip_out <= send_next && (count_d < (bit_next ? T1H_C : T0H_C));
        end
    end

    assign bit_end   = (count_q == BIT_LAST);
    assign latch_end = (count_q == LATCH_LAST);

endmodule

// File: rtl/led_frame_sequencer.sv
// Streams one frame of NUM_LEDS pixels onto a one-wire LED strip with a one-entry prefetch.
// Optional LED_FRAME_SEQUENCER_AUTO_REPEAT_EN adds stop_in and restarts frames automatically.
module led_frame_sequencer
    import led_pkg::*;
#(
    parameter int NUM_LEDS     = 64,
    parameter int T0H_CYCLES   = 20,
    parameter int T1H_CYCLES   = 40,
    parameter int BIT_CYCLES   = 62,
    parameter int RESET_CYCLES = 15000
) (
    input  logic                               clk_in,
    input  logic                               rst_n_in,
    input  logic                               start_in,
`ifdef LED_FRAME_SEQUENCER_AUTO_REPEAT_EN
    input  logic                               stop_in,
`endif
    output logic                               pixel_req_out,
    output logic [clog2_min1(NUM_LEDS)-1:0]    pixel_index_out,
    input  logic                               pixel_valid_in,
    input  logic [PIXEL_BITS-1:0]              pixel_data_in,
    output logic                               strip_out,
    output logic                               busy_out,
    output logic                               frame_done_out
);

    localparam int IDX_W     = clog2_min1(NUM_LEDS);
    localparam int BIT_IDX_W = $clog2(PIXEL_BITS);
    localparam logic [IDX_W-1:0]     LAST_PIX = IDX_W'(NUM_LEDS - 1);
    localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(PIXEL_BITS - 1);

    led_state_t           state_q,    state_d;
    logic [BIT_IDX_W-1:0] bit_idx_q,  bit_idx_d;
    pixel_t               shift_q,    shift_d;
    pixel_t               buf_q,      buf_d;
    logic                 buf_full_q, buf_full_d;
    logic [IDX_W-1:0]     cur_pix_q,  cur_pix_d;
    logic [IDX_W-1:0]     idx_d;
    logic [IDX_W-1:0]     next_pix;
    logic                 req_d, busy_d, done_d;
    logic                 handshake;
    logic                 cnt_clr, bit_end, latch_end;

    always_comb begin
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        cur_pix_d  = cur_pix_q;
        idx_d      = pixel_index_out;
        req_d      = pixel_req_out;
        done_d     = 1'b0;
        next_pix   = cur_pix_q + IDX_W'(1);
        handshake  = pixel_req_out & pixel_valid_in;

        case (state_q)
            ST_IDLE: begin
                if (start_in) begin
                    state_d = ST_FETCH;
                    idx_d   = '0;
                    req_d   = 1'b1;
                end
            end
            ST_FETCH: begin
                if (handshake) begin
                    state_d   = ST_SEND;
                    shift_d   = pixel_data_in;
                    bit_idx_d = '0;
                    cur_pix_d = pixel_index_out;
                    req_d     = (pixel_index_out != LAST_PIX);
                    if (pixel_index_out != LAST_PIX)
                        idx_d = pixel_index_out + IDX_W'(1);
                end
            end
            ST_SEND: begin
                if (handshake) begin
                    buf_d      = pixel_data_in;
                    buf_full_d = 1'b1;
                    req_d      = 1'b0;
                end
                if (bit_end) begin
                    if (bit_idx_q != LAST_BIT) begin
                        bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
                        shift_d   = {shift_q[PIXEL_BITS-2:0], 1'b0};
                    end else if (cur_pix_q == LAST_PIX) begin
                        state_d = ST_LATCH;
                    end else if (buf_full_q || handshake) begin
                        // A prefetch landing on the final bit edge goes straight to the shifter.
                        shift_d    = buf_full_q ? buf_q : pixel_data_in;
                        buf_full_d = 1'b0;
                        bit_idx_d  = '0;
                        cur_pix_d  = next_pix;
                        if (next_pix != LAST_PIX) begin
                            req_d = 1'b1;
                            idx_d = next_pix + IDX_W'(1);
                        end
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_LATCH: begin
                if (latch_end) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                    idx_d   = '0;
`ifdef LED_FRAME_SEQUENCER_AUTO_REPEAT_EN
                    if (!stop_in) begin
                        state_d = ST_FETCH;
                        req_d   = 1'b1;
                    end
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d  = (state_d != ST_IDLE);
        cnt_clr = !((state_q == state_d) &&
                    ((state_q == ST_LATCH) || ((state_q == ST_SEND) && !bit_end)));
    end

    // NOTE: outputs are flops loaded from next-state values, so they change on
    // the same edge as the state they describe rather than one cycle later.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q         <= ST_IDLE;
            bit_idx_q       <= '0;
            shift_q         <= '0;
            buf_q           <= '0;
            buf_full_q      <= 1'b0;
            cur_pix_q       <= '0;
            pixel_index_out <= '0;
            pixel_req_out   <= 1'b0;
            busy_out        <= 1'b0;
            frame_done_out  <= 1'b0;
        end else begin
            state_q         <= state_d;
            bit_idx_q       <= bit_idx_d;
            shift_q         <= shift_d;
            buf_q           <= buf_d;
            buf_full_q      <= buf_full_d;
            cur_pix_q       <= cur_pix_d;
            pixel_index_out <= idx_d;
            pixel_req_out   <= req_d;
            busy_out        <= busy_d;
            frame_done_out  <= done_d;
        end
    end

    led_bit_timer #(
        .T0H_CYCLES  (T0H_CYCLES),
        .T1H_CYCLES  (T1H_CYCLES),
        .BIT_CYCLES  (BIT_CYCLES),
        .RESET_CYCLES(RESET_CYCLES)
    ) u_bit_timer (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .clr       (cnt_clr),
        .send_next (state_d == ST_SEND),
        .bit_next  (shift_d[PIXEL_BITS-1]),
        .bit_end   (bit_end),
        .latch_end (latch_end),
        .strip_out (strip_out)
    );

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Directed bench for led_frame_sequencer: NUM_LEDS=2, T0H=2, T1H=4, BIT=6, RESET=10.
`timescale 1ns/1ps
module tb_led_frame_sequencer;

    localparam int NUM_LEDS = 2;
    localparam int T0H      = 2;
    localparam int T1H      = 4;
    localparam int BITC     = 6;
    localparam int RSTC     = 10;
    localparam int MAXC     = 700;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        start_in;
    logic        pixel_req_out;
    logic [0:0]  pixel_index_out;
    logic        pixel_valid_in;
    logic [23:0] pixel_data_in;
    logic        strip_out;
    logic        busy_out;
    logic        frame_done_out;
`ifdef LED_FRAME_SEQUENCER_AUTO_REPEAT_EN
    logic        stop_drive;
    int          stop_at;
`endif

    int checks;
    int errors;

    logic [23:0] pix [2];
    logic        s_strip [MAXC+1];
    logic        s_busy  [MAXC+1];
    logic        s_done  [MAXC+1];
    logic        s_req   [MAXC+1];
    logic [0:0]  s_idx   [MAXC+1];

    always #5 clk_in = ~clk_in;

    led_frame_sequencer #(
        .NUM_LEDS    (NUM_LEDS),
        .T0H_CYCLES  (T0H),
        .T1H_CYCLES  (T1H),
        .BIT_CYCLES  (BITC),
        .RESET_CYCLES(RSTC)
    ) dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .start_in       (start_in),
`ifdef LED_FRAME_SEQUENCER_AUTO_REPEAT_EN
        .stop_in        (stop_drive),
`endif
        .pixel_req_out  (pixel_req_out),
        .pixel_index_out(pixel_index_out),
        .pixel_valid_in (pixel_valid_in),
        .pixel_data_in  (pixel_data_in),
        .strip_out      (strip_out),
        .busy_out       (busy_out),
        .frame_done_out (frame_done_out)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge in cycle 0: start_in is high in cycle 0, samples land in s_*[n] for cycle n.
    task automatic run_frame(input int n_cycles, input int v1_cycle, input int start_a, input int start_b);
        for (int i = 0; i <= MAXC; i++) begin
            s_strip[i] = 1'b0; s_busy[i] = 1'b0; s_done[i] = 1'b0; s_req[i] = 1'b0; s_idx[i] = 1'b0;
        end
        start_in       = 1'b1;
        pixel_valid_in = 1'b1;
        pixel_data_in  = pix[0];
        for (int n = 1; n <= n_cycles; n++) begin
            @(negedge clk_in);
            s_strip[n] = strip_out;
            s_busy[n]  = busy_out;
            s_done[n]  = frame_done_out;
            s_req[n]   = pixel_req_out;
            s_idx[n]   = pixel_index_out;
            start_in       = (n == start_a) || (n == start_b);
            pixel_valid_in = (pixel_index_out == 1'b0) || (n >= v1_cycle);
            pixel_data_in  = pix[pixel_index_out];
`ifdef LED_FRAME_SEQUENCER_AUTO_REPEAT_EN
            stop_drive = (n >= stop_at);
`endif
        end
        start_in = 1'b0;
    endtask

    // Decodes 48 NRZ bits from s_strip; gap is the extra low time expected after bit 23.
    task automatic decode(input int gap, output logic [47:0] bits, output int first_rise,
                          output int bad, output int last_h);
        int n;
        int h;
        int l;
        int exp_l;
        bits = '0; bad = 0; last_h = 0;
        n = 1;
        while (n <= MAXC && s_strip[n] !== 1'b1) n++;
        first_rise = n;
        for (int b = 0; b < 48; b++) begin
            h = 0; l = 0;
            while (n <= MAXC && s_strip[n] === 1'b1) begin h++; n++; end
            while (n <= MAXC && s_strip[n] !== 1'b1) begin l++; n++; end
            bits[47-b] = (h == T1H);
            if (h != T1H && h != T0H) bad++;
            exp_l = BITC - h + ((b == 23) ? gap : 0);
            if (b < 47 && l != exp_l) bad++;
            last_h = h;
        end
    endtask

    function automatic int first_done(input int from);
        for (int n = from; n <= MAXC; n++)
            if (s_done[n] === 1'b1) return n;
        return -1;
    endfunction

    function automatic int count_done();
        int c = 0;
        for (int n = 1; n <= MAXC; n++) if (s_done[n] === 1'b1) c++;
        return c;
    endfunction

    function automatic int count_busy();
        int c = 0;
        for (int n = 1; n <= MAXC; n++) if (s_busy[n] === 1'b1) c++;
        return c;
    endfunction

    function automatic int count_req(input int from, input int to, input logic [0:0] idx);
        int c = 0;
        for (int n = from; n <= to; n++) if (s_req[n] === 1'b1 && s_idx[n] === idx) c++;
        return c;
    endfunction

    initial begin
        logic [47:0] bits;
        int          first_rise;
        int          bad;
        int          last_h;
        int          activity;

        checks = 0; errors = 0;
        rst_n_in = 1'b0; start_in = 1'b0; pixel_valid_in = 1'b0; pixel_data_in = '0;
`ifdef LED_FRAME_SEQUENCER_AUTO_REPEAT_EN
        stop_drive = 1'b1; stop_at = 0;
`endif
        repeat (3) @(negedge clk_in);
        check("rst_strip", strip_out, 0);
        check("rst_busy", busy_out, 0);
        check("rst_req", pixel_req_out, 0);
        check("rst_idx", pixel_index_out, 0);
        check("rst_done", frame_done_out, 0);
        rst_n_in = 1'b1;

        // Idle with valid high: nothing may move
        pixel_valid_in = 1'b1; pixel_data_in = 24'hFFFFFF; activity = 0;
        repeat (20) begin
            @(negedge clk_in);
            if (strip_out || busy_out || pixel_req_out || pixel_index_out != 1'b0 || frame_done_out)
                activity++;
        end
        check("idle_activity", activity, 0);

        // Frame 1: gapless frame with valid tied high
        pix[0] = 24'hFF0000; pix[1] = 24'h000001;
        run_frame(310, 0, -1, -1);
        decode(0, bits, first_rise, bad, last_h);
        check("f1_first_rise", first_rise, 2);
        check("f1_bits", bits, 48'hFF0000_000001);
        check("f1_bit_timing", bad, 0);
        check("f1_last_bit_high", last_h, T1H);
        check("f1_done_at", first_done(1), 300);
        check("f1_done_count", count_done(), 1);
        check("f1_busy_cycles", count_busy(), 299);
        check("f1_busy_at_done", s_busy[300], 0);
        check("f1_req_c1", {s_req[1], s_idx[1]}, 2'b10);
        check("f1_req_c2", {s_req[2], s_idx[2]}, 2'b11);
        check("f1_req_count", count_req(1, MAXC, 1'b0) + count_req(1, MAXC, 1'b1), 2);

        // Frame 2: pixel 1 arrives 200 cycles after its request (stall 146..202)
        pix[0] = 24'h5A0F81; pix[1] = 24'h800001;
        run_frame(370, 202, -1, -1);
        decode(57, bits, first_rise, bad, last_h);
        check("stall_first_rise", first_rise, 2);
        check("stall_bits", bits, 48'h5A0F81_800001);
        check("stall_bit_timing", bad, 0);
        check("stall_req_held", count_req(2, 202, 1'b1), 201);
        check("stall_req_drop", s_req[203], 0);
        check("stall_done_at", first_done(1), 357);
        check("stall_done_count", count_done(), 1);

        // Frame 3: start ignored mid-frame, accepted in the done cycle
        pix[0] = 24'h00FF00; pix[1] = 24'hABCDEF;
        run_frame(640, 0, 100, 300);
        decode(0, bits, first_rise, bad, last_h);
        check("restart_bits", bits, 48'h00FF00_ABCDEF);
        check("restart_first_done", first_done(1), 300);
        check("restart_busy_at_done", s_busy[300], 0);
        check("restart_req_next", {s_req[301], s_idx[301]}, 2'b10);
        check("restart_busy_next", s_busy[301], 1);
        check("restart_second_done", first_done(301), 600);
        check("restart_done_count", count_done(), 2);
        check("restart_idle_after", s_busy[620], 0);

        // Reset pulse at bit 5 of pixel 0 (cycles 32..37, high 32..35)
        pix[0] = 24'hFF0000; pix[1] = 24'h000001;
        run_frame(34, 0, -1, -1);
        check("midbit_strip_high", s_strip[34], 1);
        check("midbit_idx", pixel_index_out, 1);
        rst_n_in = 1'b0;
        #1;
        check("async_rst_strip", strip_out, 0);
        check("async_rst_busy", busy_out, 0);
        check("async_rst_req", pixel_req_out, 0);
        check("async_rst_idx", pixel_index_out, 0);
        check("async_rst_done", frame_done_out, 0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        repeat (5) @(negedge clk_in);
        check("post_rst_busy", busy_out, 0);
        pix[0] = 24'hC0FFEE; pix[1] = 24'h123456;
        run_frame(310, 0, -1, -1);
        decode(0, bits, first_rise, bad, last_h);
        check("post_rst_first_rise", first_rise, 2);
        check("post_rst_bits", bits, 48'hC0FFEE_123456);
        check("post_rst_bit_timing", bad, 0);
        check("post_rst_done_at", first_done(1), 300);

`ifdef LED_FRAME_SEQUENCER_AUTO_REPEAT_EN
        // Auto repeat: stop_in low through frame 1, raised during frame 2
        pix[0] = 24'h0F0F0F; pix[1] = 24'hF0F0F0;
        stop_at = 400; stop_drive = 1'b0;
        run_frame(700, 0, -1, -1);
        check("auto_done_at", first_done(1), 300);
        check("auto_busy_at_done", s_busy[300], 1);
        check("auto_req_idx0", count_req(300, 301, 1'b0) > 0, 1);
        check("auto_done_count", count_done(), 2);
        check("auto_second_done", (first_done(301) >= 598) && (first_done(301) <= 600), 1);
        check("auto_stop_idle", s_busy[700], 0);
        stop_at = 0; stop_drive = 1'b1;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
